// File: rtl/qif_pkg.sv
// Shared types, default neuron constants and the saturation helper for the QIF neuron array.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qif_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int QIF_V_RESET = -20;
  localparam int QIF_V_PEAK  = 50;
  localparam int QIF_SHIFT_V = 3;
  localparam int QIF_SHIFT_B = 2;

  // Clamp a wide signed value into the signed range of a w-bit word (w <= 63).
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/qif_update.sv
// Combinational single-neuron QIF step: quadratic drift, saturation, threshold and refractory hold.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is written back.
// Ports: v/b/refrac_cnt = current membrane, current, refractory count;
//        v_next/spike/refrac_next = updated membrane, spike flag, next refractory count.
module qif_update
  import qif_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int V_RESET      = QIF_V_RESET,
  parameter int V_PEAK       = QIF_V_PEAK,
  parameter int SHIFT_V      = QIF_SHIFT_V,
  parameter int SHIFT_B      = QIF_SHIFT_B,
  parameter int REFRAC_TICKS = 2,
  parameter int CW           = 2
) (
  input  logic signed [WIDTH-1:0] v,
  input  logic signed [WIDTH-1:0] b,
  input  logic        [CW-1:0]    refrac_cnt,
  output logic signed [WIDTH-1:0] v_next,
  output logic                    spike,
  output logic        [CW-1:0]    refrac_next
);

  // 3*WIDTH holds the full product of two shifted V terms and one shifted B term,
  // plus the addition of V, without any loss.
  localparam int PW = 3 * WIDTH;
  localparam logic signed [WIDTH-1:0] V_RESET_W = WIDTH'(V_RESET);
  localparam logic signed [WIDTH-1:0] V_PEAK_W  = WIDTH'(V_PEAK);

  logic signed [WIDTH-1:0] vs;
  logic signed [WIDTH-1:0] bs;
  logic signed [PW-1:0]    vs_w;
  logic signed [PW-1:0]    bs_w;
  logic signed [PW-1:0]    v_w;
  logic signed [PW-1:0]    dv;
  logic signed [PW-1:0]    sum;
  logic signed [63:0]      sum64;
  logic signed [WIDTH-1:0] v_sat;

  assign vs    = v >>> SHIFT_V;
  assign bs    = b >>> SHIFT_B;
  assign vs_w  = {{(PW-WIDTH){vs[WIDTH-1]}}, vs};
  assign bs_w  = {{(PW-WIDTH){bs[WIDTH-1]}}, bs};
  assign v_w   = {{(PW-WIDTH){v[WIDTH-1]}}, v};
  assign dv    = vs_w * vs_w * bs_w;
  assign sum   = v_w + dv;
  assign sum64 = {{(64-PW){sum[PW-1]}}, sum};
  assign v_sat = WIDTH'(sat_signed(sum64, WIDTH));

  always_comb begin
    v_next      = v_sat;
    spike       = 1'b0;
    refrac_next = '0;
    if (refrac_cnt != '0) begin
      // Still refractory: pinned at reset, no integration.
      v_next      = V_RESET_W;
      refrac_next = refrac_cnt - CW'(1);
    end else if (v_sat >= V_PEAK_W) begin
      v_next      = V_RESET_W;
      spike       = 1'b1;
      refrac_next = CW'(REFRAC_TICKS);
    end
  end

endmodule

// File: rtl/qif_neuron_array.sv
// Array of QIF neurons sharing one update datapath, one neuron per cycle per tick-triggered sweep.
// Latency: tick accepted in cycle t -> done_o in cycle t+NUM_NEURONS+1; spike_o updates after done.
// Backpressure: none; ticks arriving while busy are dropped and reported on tick_drop_o.
// Ports: clk/rst_n; tick_i starts a sweep; b_i packed currents; busy_o/done_o sweep status;
//        spike_o last-sweep spikes; v_o packed membrane values; tick_drop_o overrun pulse.
module qif_neuron_array
  import qif_pkg::*;
#(
  parameter int NUM_NEURONS  = 4,
  parameter int WIDTH        = 8,
  parameter int V_RESET      = QIF_V_RESET,
  parameter int V_PEAK       = QIF_V_PEAK,
  parameter int SHIFT_V      = QIF_SHIFT_V,
  parameter int SHIFT_B      = QIF_SHIFT_B,
  parameter int REFRAC_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick_i,
  input  logic [NUM_NEURONS*WIDTH-1:0] b_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NUM_NEURONS-1:0]       spike_o,
  output logic [NUM_NEURONS*WIDTH-1:0] v_o,
  output logic                         tick_drop_o
);

  localparam int CW = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;
  localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);
  localparam logic signed [WIDTH-1:0] V_RESET_W = WIDTH'(V_RESET);

  state_t                  state_q;
  state_t                  state_d;
  logic [IW-1:0]           idx_q;
  logic signed [WIDTH-1:0] b_q   [NUM_NEURONS];
  logic signed [WIDTH-1:0] v_q   [NUM_NEURONS];
  logic [CW-1:0]           cnt_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]  acc_q;

  logic signed [WIDTH-1:0] v_upd;
  logic                    spike_upd;
  logic [CW-1:0]           cnt_upd;

  qif_update #(
    .WIDTH       (WIDTH),
    .V_RESET     (V_RESET),
    .V_PEAK      (V_PEAK),
    .SHIFT_V     (SHIFT_V),
    .SHIFT_B     (SHIFT_B),
    .REFRAC_TICKS(REFRAC_TICKS),
    .CW          (CW)
  ) u_update (
    .v          (v_q[idx_q]),
    .b          (b_q[idx_q]),
    .refrac_cnt (cnt_q[idx_q]),
    .v_next     (v_upd),
    .spike      (spike_upd),
    .refrac_next(cnt_upd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick_i) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      spike_o     <= '0;
      tick_drop_o <= 1'b0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_q[k]   <= V_RESET_W;
        cnt_q[k] <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      // DONE counts as busy, so a tick on the DONE->IDLE edge is dropped too.
      tick_drop_o <= tick_i && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (tick_i) begin
            // Currents are frozen for the whole sweep.
            for (int k = 0; k < NUM_NEURONS; k++) b_q[k] <= b_i[k*WIDTH +: WIDTH];
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        RUN: begin
          v_q[idx_q]   <= v_upd;
          cnt_q[idx_q] <= cnt_upd;
          acc_q[idx_q] <= spike_upd;
          if (idx_q != LAST_IDX) idx_q <= idx_q + IW'(1);
        end
        DONE:    spike_o <= acc_q;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_vo
    assign v_o[g*WIDTH +: WIDTH] = v_q[g];
  end

endmodule
